// File: rtl/seu_mon_pkg.sv
// seu_mon_pkg
// Shared definitions for the SEU error monitor: the 2-bit health state type,
// its encoding constants, and a width helper for source-index fields.
package seu_mon_pkg;

  typedef enum logic [1:0] {
    ST_OK        = 2'd0,
    ST_CORRECTED = 2'd1,
    ST_DEGRADED  = 2'd2,
    ST_FATAL     = 2'd3
  } seu_state_e;

  localparam logic [1:0] STATE_OK        = 2'd0;
  localparam logic [1:0] STATE_CORRECTED = 2'd1;
  localparam logic [1:0] STATE_DEGRADED  = 2'd2;
  localparam logic [1:0] STATE_FATAL     = 2'd3;

  // A single source still needs a 1-bit index field.
  function automatic int src_width(input int num_src);
    return (num_src > 1) ? $clog2(num_src) : 1;
  endfunction

endpackage

// File: rtl/seu_sat_counter.sv
// seu_sat_counter
// Event counter that adds a multi-bit increment every cycle and sticks at its
// all-ones value instead of wrapping.
// Ports:
//   clk_i   clock
//   rstn_i  asynchronous active-low reset
//   clr_i   synchronous clear, priority over the increment
//   inc_i   amount to add this cycle
//   cnt_o   registered count
module seu_sat_counter #(
  parameter int CNT_WIDTH = 16,
  parameter int INC_WIDTH = 3
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 clr_i,
  input  logic [INC_WIDTH-1:0] inc_i,
  output logic [CNT_WIDTH-1:0] cnt_o
);

  // One bit wider than the larger operand so the carry-out is never lost.
  localparam int SUM_W = ((CNT_WIDTH > INC_WIDTH) ? CNT_WIDTH : INC_WIDTH) + 1;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_WIDTH{1'b1}});

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [SUM_W-1:0]     sum;

  always_comb begin
    sum = SUM_W'(cnt_q) + SUM_W'(inc_i);
    if (clr_i) begin
      cnt_d = '0;
    end else if (sum > CNT_MAX) begin
      cnt_d = '1;
    end else begin
      cnt_d = sum[CNT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/seu_err_monitor.sv
// seu_err_monitor
// Collects single/double error flags from a bank of triplicated voter
// registers into saturating counters, a frozen first-error record, a health
// state and a sticky interrupt.
// Ports:
//   clk_i, rstn_i          clock, asynchronous active-low reset
//   error1_i / error2_i    per-source single (corrected) / double (uncorrected) flags
//   enable_i               low = error inputs ignored
//   clear_i                synchronous clear of everything
//   threshold_i            single-error count that raises DEGRADED; 0 disables
//   cnt1_o / cnt2_o        saturating single / double event counts
//   first_valid_o, first_src_o, first_type_o   first-error record
//   state_o, irq_o         health state and sticky interrupt
//
// state        | meaning
// -------------+-----------------------------------------------------
// OK           | no error seen since reset/clear
// CORRECTED    | single errors seen, below threshold
// DEGRADED     | single-error count reached the threshold
// FATAL        | a double error was seen; absorbing until clear/reset
module seu_err_monitor
  import seu_mon_pkg::*;
#(
  parameter int NUM_SRC   = 4,
  parameter int CNT_WIDTH = 16,
  localparam int SRC_W    = src_width(NUM_SRC)
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic [NUM_SRC-1:0]   error1_i,
  input  logic [NUM_SRC-1:0]   error2_i,
  input  logic                 enable_i,
  input  logic                 clear_i,
  input  logic [CNT_WIDTH-1:0] threshold_i,
  output logic [CNT_WIDTH-1:0] cnt1_o,
  output logic [CNT_WIDTH-1:0] cnt2_o,
  output logic                 first_valid_o,
  output logic [SRC_W-1:0]     first_src_o,
  output logic                 first_type_o,
  output logic [1:0]           state_o,
  output logic                 irq_o
);

  localparam int INC_W = $clog2(NUM_SRC + 1);
  localparam int SUM_W = ((CNT_WIDTH > INC_W) ? CNT_WIDTH : INC_W) + 1;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_WIDTH{1'b1}});

  function automatic logic [INC_W-1:0] popcount(input logic [NUM_SRC-1:0] v);
    logic [INC_W-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      c = c + INC_W'(v[i]);
    end
    return c;
  endfunction

  function automatic logic [SRC_W-1:0] lowest_idx(input logic [NUM_SRC-1:0] v);
    logic [SRC_W-1:0] idx;
    idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (v[i]) idx = SRC_W'(i);
    end
    return idx;
  endfunction

  logic [NUM_SRC-1:0]   err1_q, err1_d, err2_q, err2_d;
  logic [NUM_SRC-1:0]   single_v;
  logic [INC_W-1:0]     inc1, inc2;
  logic [SUM_W-1:0]     sum1;
  logic [CNT_WIDTH-1:0] cnt1_nxt;
  logic                 any_single, any_double, thr_hit;
  logic                 first_valid_q, first_valid_d;
  logic [SRC_W-1:0]     first_src_q, first_src_d;
  logic                 first_type_q, first_type_d;
  seu_state_e           state_q, state_d;
  logic                 irq_q, irq_d;

  // A source flagging both errors counts as a double error only.
  assign single_v   = err1_q & ~err2_q;
  assign inc1       = popcount(single_v);
  assign inc2       = popcount(err2_q);
  assign any_single = |single_v;
  assign any_double = |err2_q;

  // Next single-error count, saturated the same way as the counter, so the
  // threshold is judged on the value the counter is about to hold.
  always_comb begin
    sum1 = SUM_W'(cnt1_o) + SUM_W'(inc1);
    cnt1_nxt = (sum1 > CNT_MAX) ? '1 : sum1[CNT_WIDTH-1:0];
  end

  assign thr_hit = (threshold_i != '0) && (cnt1_nxt >= threshold_i);

  always_comb begin
    err1_d = enable_i ? error1_i : '0;
    err2_d = enable_i ? error2_i : '0;
    if (clear_i) begin
      err1_d = '0;
      err2_d = '0;
    end
  end

  always_comb begin
    first_valid_d = first_valid_q;
    first_src_d   = first_src_q;
    first_type_d  = first_type_q;
    if (clear_i) begin
      first_valid_d = 1'b0;
      first_src_d   = '0;
      first_type_d  = 1'b0;
    end else if (!first_valid_q && (any_single || any_double)) begin
      first_valid_d = 1'b1;
      first_type_d  = any_double;
      first_src_d   = any_double ? lowest_idx(err2_q) : lowest_idx(err1_q);
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = ST_OK;
    end else if (any_double) begin
      state_d = ST_FATAL;
    end else begin
      case (state_q)
        ST_OK:        if (any_single) state_d = thr_hit ? ST_DEGRADED : ST_CORRECTED;
        ST_CORRECTED: if (thr_hit) state_d = ST_DEGRADED;
        default:      state_d = state_q;
      endcase
    end
  end

  always_comb begin
    irq_d = irq_q || (state_d == ST_DEGRADED) || (state_d == ST_FATAL);
    if (clear_i) irq_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      err1_q        <= '0;
      err2_q        <= '0;
      first_valid_q <= 1'b0;
      first_src_q   <= '0;
      first_type_q  <= 1'b0;
      state_q       <= ST_OK;
      irq_q         <= 1'b0;
    end else begin
      err1_q        <= err1_d;
      err2_q        <= err2_d;
      first_valid_q <= first_valid_d;
      first_src_q   <= first_src_d;
      first_type_q  <= first_type_d;
      state_q       <= state_d;
      irq_q         <= irq_d;
    end
  end

  seu_sat_counter #(
    .CNT_WIDTH(CNT_WIDTH),
    .INC_WIDTH(INC_W)
  ) u_cnt1 (
    .clk_i (clk_i),
    .rstn_i(rstn_i),
    .clr_i (clear_i),
    .inc_i (inc1),
    .cnt_o (cnt1_o)
  );

  seu_sat_counter #(
    .CNT_WIDTH(CNT_WIDTH),
    .INC_WIDTH(INC_W)
  ) u_cnt2 (
    .clk_i (clk_i),
    .rstn_i(rstn_i),
    .clr_i (clear_i),
    .inc_i (inc2),
    .cnt_o (cnt2_o)
  );

  assign first_valid_o = first_valid_q;
  assign first_src_o   = first_src_q;
  assign first_type_o  = first_type_q;
  assign state_o       = state_q;
  assign irq_o         = irq_q;

endmodule

// File: tb/tb_seu_err_monitor.sv
module tb_seu_err_monitor;

  localparam int NUM_SRC   = 4;
  localparam int CNT_WIDTH = 4;
  localparam int MAXC      = 15;

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic [NUM_SRC-1:0]   error1 = '0;
  logic [NUM_SRC-1:0]   error2 = '0;
  logic                 enable = 1'b1;
  logic                 clear = 1'b0;
  logic [CNT_WIDTH-1:0] threshold = 4'd3;
  logic [CNT_WIDTH-1:0] cnt1, cnt2;
  logic                 first_valid, first_type, irq;
  logic [1:0]           first_src, state;

  int errors = 0;
  int checks = 0;

  seu_err_monitor #(
    .NUM_SRC  (NUM_SRC),
    .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .error1_i     (error1),
    .error2_i     (error2),
    .enable_i     (enable),
    .clear_i      (clear),
    .threshold_i  (threshold),
    .cnt1_o       (cnt1),
    .cnt2_o       (cnt2),
    .first_valid_o(first_valid),
    .first_src_o  (first_src),
    .first_type_o (first_type),
    .state_o      (state),
    .irq_o        (irq)
  );

  always #5 clk = ~clk;

  // Behavioural model: the bits sampled last edge (m_p1/m_p2) are applied to
  // integer counts and a severity level at this edge.
  int m_c1, m_c2, m_fs, m_st, n1, n2;
  bit m_fv, m_ft, m_irq, deg;
  logic [NUM_SRC-1:0] m_p1, m_p2, m_s, m_pick;

  task automatic model_zero();
    m_c1 = 0; m_c2 = 0; m_fv = 0; m_ft = 0; m_fs = 0; m_st = 0; m_irq = 0;
    m_p1 = '0; m_p2 = '0;
  endtask

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      model_zero();
    end else if (clear) begin
      model_zero();
    end else begin
      m_s = m_p1 & ~m_p2;
      n1 = m_c1 + $countones(m_s);
      if (n1 > MAXC) n1 = MAXC;
      n2 = m_c2 + $countones(m_p2);
      if (n2 > MAXC) n2 = MAXC;
      if (!m_fv && (m_p1 | m_p2) != 0) begin
        m_fv = 1;
        m_ft = (m_p2 != 0);
        m_pick = (m_p2 != 0) ? m_p2 : m_p1;
        for (int i = NUM_SRC - 1; i >= 0; i--) if (m_pick[i]) m_fs = i;
      end
      deg = (threshold != 0) && (n1 >= int'(threshold));
      if (m_p2 != 0) m_st = 3;
      else if (m_st == 0 && m_s != 0) m_st = deg ? 2 : 1;
      else if (m_st == 1 && deg) m_st = 2;
      if (m_st >= 2) m_irq = 1;
      m_c1 = n1;
      m_c2 = n2;
      m_p1 = enable ? error1 : '0;
      m_p2 = enable ? error2 : '0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("cnt1", 32'(cnt1), 32'(m_c1));
    chk("cnt2", 32'(cnt2), 32'(m_c2));
    chk("first_valid", 32'(first_valid), 32'(m_fv));
    if (m_fv) begin
      chk("first_src", 32'(first_src), 32'(m_fs));
      chk("first_type", 32'(first_type), 32'(m_ft));
    end
    chk("state", 32'(state), 32'(m_st));
    chk("irq", 32'(irq), 32'(m_irq));
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cnt1"}, 32'(cnt1), 0);
    chk({tag, "_cnt2"}, 32'(cnt2), 0);
    chk({tag, "_fv"}, 32'(first_valid), 0);
    chk({tag, "_fsrc"}, 32'(first_src), 0);
    chk({tag, "_ftype"}, 32'(first_type), 0);
    chk({tag, "_state"}, 32'(state), 0);
    chk({tag, "_irq"}, 32'(irq), 0);
  endtask

  initial begin
    #2;
    chk_all_zero("in_reset");
    #10 rstn = 1'b1;
    step();
    chk_all_zero("after_reset");

    // single error on source 2, visible two edges after it is driven
    error1 = 4'b0100;
    step();
    error1 = '0;
    chk("lat_cnt1_early", 32'(cnt1), 0);
    step();
    chk("first_cnt1", 32'(cnt1), 1);
    chk("first_fv", 32'(first_valid), 1);
    chk("first_src", 32'(first_src), 2);
    chk("first_type", 32'(first_type), 0);
    chk("first_state", 32'(state), 1);
    chk("first_irq", 32'(irq), 0);
    chk("model_c1", 32'(m_c1), 1);
    chk("model_st", 32'(m_st), 1);

    // threshold crossing
    do_clear();
    chk_all_zero("clear1");
    threshold = 4'd3;
    error1 = 4'b0011;
    step(2);
    error1 = '0;
    chk("thr_cnt1_a", 32'(cnt1), 2);
    chk("thr_state_a", 32'(state), 1);
    step();
    chk("thr_cnt1_b", 32'(cnt1), 4);
    chk("thr_state_b", 32'(state), 2);
    chk("thr_irq", 32'(irq), 1);
    chk("model_irq", 32'(m_irq), 1);
    do_clear();
    chk_all_zero("clear2");

    // double error wins the first-error record
    error1 = 4'b0001;
    error2 = 4'b1000;
    step();
    error1 = '0;
    error2 = '0;
    step();
    chk("dbl_src", 32'(first_src), 3);
    chk("dbl_type", 32'(first_type), 1);
    chk("dbl_cnt1", 32'(cnt1), 1);
    chk("dbl_cnt2", 32'(cnt2), 1);
    chk("dbl_state", 32'(state), 3);
    chk("dbl_irq", 32'(irq), 1);
    error1 = 4'b0010;
    step();
    error1 = '0;
    step();
    chk("fatal_hold", 32'(state), 3);
    chk("fatal_cnt1", 32'(cnt1), 2);
    chk("fatal_src_frozen", 32'(first_src), 3);

    // saturation
    do_clear();
    threshold = 4'd0;
    error1 = 4'b1111;
    step(5);
    error1 = '0;
    step();
    chk("sat_cnt1", 32'(cnt1), 15);
    chk("sat_state", 32'(state), 1);
    step(2);
    chk("sat_hold", 32'(cnt1), 15);

    // enable low ignores errors
    do_clear();
    enable = 1'b0;
    error1 = 4'b1111;
    error2 = 4'b0101;
    step(2);
    chk("en_cnt1", 32'(cnt1), 0);
    chk("en_cnt2", 32'(cnt2), 0);
    chk("en_fv", 32'(first_valid), 0);
    chk("en_state", 32'(state), 0);
    enable = 1'b1;
    error1 = '0;
    error2 = '0;

    // clear in the same cycle as an error drops it
    clear = 1'b1;
    error1 = 4'b0001;
    step();
    clear = 1'b0;
    error1 = '0;
    step(2);
    chk("clr_drop_cnt1", 32'(cnt1), 0);
    chk("clr_drop_fv", 32'(first_valid), 0);

    // asynchronous reset mid-count
    error1 = 4'b0001;
    step(7);
    error1 = '0;
    step();
    chk("pre_rst_cnt1", 32'(cnt1), 7);
    #2 rstn = 1'b0;
    #1;
    chk_all_zero("async_rst");
    #3 rstn = 1'b1;
    step();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      error1 = ($urandom_range(0, 2) == 0) ? NUM_SRC'($urandom) : '0;
      error2 = ($urandom_range(0, 24) == 0) ? NUM_SRC'(1 << $urandom_range(0, NUM_SRC - 1)) : '0;
      enable = ($urandom_range(0, 9) != 0);
      clear  = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 19) == 0) threshold = CNT_WIDTH'($urandom_range(0, MAXC));
      step();
    end
    clear = 1'b0;
    error1 = '0;
    error2 = '0;
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
